// File: rtl/router_pkg.sv
// Shared widths and forwarder state encoding for the router ingress path.
package router_pkg;

    localparam int N_PORTS = 4;
    localparam int PORT_W  = 2;
    localparam int ADDR_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        HDR,
        BODY
    } fwd_state_t;

    function automatic logic [N_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] port);
        logic [N_PORTS-1:0] r_mask;
        r_mask       = '0;
        r_mask[port] = 1'b1;
        return r_mask;
    endfunction

endpackage

// File: rtl/packet_forwarder_if.sv
// Ingress byte stream plus shared-data, one-hot-valid egress stream of the forwarder.
interface packet_forwarder_if;
    import router_pkg::*;

    logic [ADDR_W-1:0]  in_data;
    logic               in_valid;
    logic               in_sop;
    logic               in_eop;
    logic               in_ready;

    logic [ADDR_W-1:0]  out_data;
    logic               out_sop;
    logic               out_eop;
    logic [N_PORTS-1:0] out_valid;
    logic [N_PORTS-1:0] out_ready;

    modport master (
        output in_data, in_valid, in_sop, in_eop, out_ready,
        input  in_ready, out_data, out_sop, out_eop, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, out_ready,
        output in_ready, out_data, out_sop, out_eop, out_valid
    );

endinterface

// File: rtl/fwd_lat_timer.sv
// Count-down timer covering the fixed latency of the routing table lookup.
module fwd_lat_timer #(
    parameter int unsigned LOOKUP_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (LOOKUP_LAT < 1) ? 1 : $clog2(LOOKUP_LAT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CW'(LOOKUP_LAT);
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/router.sv
// Routing table: direct-mapped port entries; index/found registered, then port.
module router
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              setup,
    input  logic [ADDR_W-1:0] Address,
    input  logic [PORT_W-1:0] p,
    output logic [PORT_W-1:0] Port
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [PORT_W-1:0] r_tbl [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_idx;
    logic              r_found;
    logic [PORT_W-1:0] r_port;

    always_ff @(posedge clk) begin
        if (setup) begin
            r_tbl[Address] <= p;
        end
    end

    // Entries never written report port 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_idx   <= '0;
            r_found <= 1'b0;
            r_port  <= '0;
        end else begin
            if (setup) begin
                r_valid[Address] <= 1'b1;
            end
            r_idx   <= Address;
            r_found <= r_valid[Address];
            r_port  <= r_found ? r_tbl[r_idx] : '0;
        end
    end

    assign Port = r_port;

endmodule

// File: rtl/packet_forwarder.sv
// Ingress stage: looks up the header address in the table, then streams the packet to one port.
module packet_forwarder
    import router_pkg::*;
#(
    parameter int unsigned LOOKUP_LAT = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              setup,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [PORT_W-1:0] cfg_port,
    output logic              rt_setup,
    output logic [ADDR_W-1:0] lkp_addr,
    output logic [PORT_W-1:0] lkp_p,
    input  logic [PORT_W-1:0] lkp_port,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  drop_count,
    packet_forwarder_if.slave bus
);

    fwd_state_t        r_state;
    fwd_state_t        w_next;
    logic [ADDR_W-1:0] r_hdr;
    logic              r_hdr_eop;
    logic [PORT_W-1:0] r_dest;
    logic [CNT_W-1:0]  r_pkt_count;
    logic [CNT_W-1:0]  r_drop_count;
    logic              w_hdr_take;
    logic              w_drop;
    logic              w_pkt_done;
    logic              w_in_lookup;
    logic              w_lat_done;

    assign w_in_lookup = (r_state == LOOKUP);

    fwd_lat_timer #(
        .LOOKUP_LAT(LOOKUP_LAT)
    ) u_lat_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_hdr_take),
        .en    (w_in_lookup),
        .done  (w_lat_done)
    );

    always_comb begin
        w_next        = r_state;
        w_hdr_take    = 1'b0;
        w_drop        = 1'b0;
        w_pkt_done    = 1'b0;
        rt_setup      = 1'b0;
        lkp_addr      = r_hdr;
        lkp_p         = '0;
        bus.in_ready  = 1'b0;
        bus.out_valid = '0;
        bus.out_data  = r_hdr;
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (setup) begin
                    rt_setup = 1'b1;
                    lkp_addr = cfg_addr;
                    lkp_p    = cfg_port;
                end else begin
                    bus.in_ready = 1'b1;
                    if (bus.in_valid) begin
                        if (bus.in_sop) begin
                            w_hdr_take = 1'b1;
                            w_next     = LOOKUP;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end
            end
            LOOKUP: begin
                if (w_lat_done) begin
                    w_next = HDR;
                end
            end
            HDR: begin
                bus.out_valid = port_onehot(r_dest);
                bus.out_sop   = 1'b1;
                bus.out_eop   = r_hdr_eop;
                if (bus.out_ready[r_dest]) begin
                    w_next     = r_hdr_eop ? IDLE : BODY;
                    w_pkt_done = r_hdr_eop;
                end
            end
            BODY: begin
                // Passthrough: in_sop is deliberately ignored here.
                bus.out_data = bus.in_data;
                bus.out_eop  = bus.in_eop;
                bus.in_ready = bus.out_ready[r_dest];
                if (bus.in_valid) begin
                    bus.out_valid = port_onehot(r_dest);
                    if (bus.out_ready[r_dest] && bus.in_eop) begin
                        w_pkt_done = 1'b1;
                        w_next     = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hdr        <= '0;
            r_hdr_eop    <= 1'b0;
            r_dest       <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_hdr_take) begin
                r_hdr     <= bus.in_data;
                r_hdr_eop <= bus.in_eop;
            end
            if (w_in_lookup && w_lat_done) begin
                r_dest <= lkp_port;
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_packet_forwarder.sv
// Directed bench: router table + forwarder, egress checked by a queue-based scoreboard monitor.
module tb_packet_forwarder;
    import router_pkg::*;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        rt_reset = 1'b1;
    logic        setup    = 1'b0;
    logic [7:0]  cfg_addr = 8'h00;
    logic [1:0]  cfg_port = 2'd0;
    logic        rt_setup;
    logic [7:0]  lkp_addr;
    logic [1:0]  lkp_p;
    logic [1:0]  lkp_port;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_pops   = 0;
    exp_t q[$];
    exp_t e_head;

    packet_forwarder_if bus();

    packet_forwarder #(
        .LOOKUP_LAT(2),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .setup      (setup),
        .cfg_addr   (cfg_addr),
        .cfg_port   (cfg_port),
        .rt_setup   (rt_setup),
        .lkp_addr   (lkp_addr),
        .lkp_p      (lkp_p),
        .lkp_port   (lkp_port),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .bus        (bus)
    );

    router u_router (
        .clk     (clk),
        .reset   (rt_reset),
        .setup   (rt_setup),
        .Address (lkp_addr),
        .p       (lkp_p),
        .Port    (lkp_port)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] p);
        logic [3:0] m;
        m = 4'b0001 << p;
        return m;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endfunction

    function void push(input logic [1:0] p, input logic [7:0] d, input logic s, input logic e);
        exp_t x;
        x.port = p;
        x.data = d;
        x.sop  = s;
        x.eop  = e;
        q.push_back(x);
    endfunction

    // Scoreboard monitor: every presented egress byte must match the queue head.
    always @(negedge clk) begin
        if (!reset && (bus.out_valid != 4'b0000)) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_egress: out_valid=%b data=0x%0h, expected no egress",
                         bus.out_valid, bus.out_data);
            end else begin
                e_head = q[0];
                if ((bus.out_valid & bus.out_ready) != 4'b0000) begin
                    void'(q.pop_front());
                    n_pops++;
                    chk("egress_valid", 32'(bus.out_valid), 32'(oh(e_head.port)));
                    chk("egress_data", 32'(bus.out_data), 32'(e_head.data));
                    chk("egress_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'({e_head.sop, e_head.eop}));
                end else begin
                    chk("stall_valid", 32'(bus.out_valid), 32'(oh(e_head.port)));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        bit got;
        got          = 1'b0;
        bus.in_data  = d;
        bus.in_sop   = s;
        bus.in_eop   = e;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, expected accept within 100 cycles", d);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [1:0] p);
        setup    = 1'b1;
        cfg_addr = a;
        cfg_port = p;
        @(negedge clk);
        chk("cfg_rt_setup", 32'(rt_setup), 32'd1);
        chk("cfg_in_ready", 32'(bus.in_ready), 32'd0);
        chk("cfg_lkp_addr", 32'(lkp_addr), 32'(a));
        chk("cfg_lkp_p", 32'(lkp_p), 32'(p));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_eop    = 1'b0;
        bus.out_ready = 4'hF;

        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sop_eop", 32'({bus.out_sop, bus.out_eop}), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_rt_setup", 32'(rt_setup), 32'd0);
        chk("rst_lkp_addr", 32'(lkp_addr), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rt_reset = 1'b0;

        // 1: table fill, then a 3-byte packet to port 1 with non-dest ports stalled
        cfg_write(8'h11, 2'd2);
        cfg_write(8'h22, 2'd1);
        cfg_write(8'h33, 2'd3);
        setup = 1'b0;
        bus.out_ready = 4'b0010;
        push(2'd1, 8'h22, 1'b1, 1'b0); send_byte(8'h22, 1'b1, 1'b0);
        push(2'd1, 8'hA0, 1'b0, 1'b0); send_byte(8'hA0, 1'b0, 1'b0);
        push(2'd1, 8'hA1, 1'b0, 1'b1); send_byte(8'hA1, 1'b0, 1'b1);
        drain();
        chk("t1_pkt_count", 32'(pkt_count), 32'd1);
        bus.out_ready = 4'hF;

        // 2: unknown address defaults to port 0
        push(2'd0, 8'h99, 1'b1, 1'b0); send_byte(8'h99, 1'b1, 1'b0);
        push(2'd0, 8'h01, 1'b0, 1'b0); send_byte(8'h01, 1'b0, 1'b0);
        push(2'd0, 8'h02, 1'b0, 1'b1); send_byte(8'h02, 1'b0, 1'b1);
        drain();
        chk("t2_pkt_count", 32'(pkt_count), 32'd2);

        // 3: port 2 stalls for 5 cycles while byte 0xB1 is pending
        base = n_pops;
        fork
            begin
                push(2'd2, 8'h11, 1'b1, 1'b0); send_byte(8'h11, 1'b1, 1'b0);
                push(2'd2, 8'hB0, 1'b0, 1'b0); send_byte(8'hB0, 1'b0, 1'b0);
                push(2'd2, 8'hB1, 1'b0, 1'b0); send_byte(8'hB1, 1'b0, 1'b0);
                push(2'd2, 8'hB2, 1'b0, 1'b1); send_byte(8'hB2, 1'b0, 1'b1);
            end
            begin
                for (int n = 0; n < 200 && n_pops < base + 2; n++) begin
                    @(negedge clk);
                    #1;
                end
                @(posedge clk);
                #1;
                bus.out_ready[2] = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("bp_out_data", 32'(bus.out_data), 32'hB1);
                    chk("bp_out_valid", 32'(bus.out_valid), 32'h4);
                end
                @(posedge clk);
                #1;
                bus.out_ready[2] = 1'b1;
            end
        join
        drain();
        chk("t3_pkt_count", 32'(pkt_count), 32'd3);

        // 4: non-SOP bytes in IDLE are discarded
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0, 1'b0);
        drain();
        chk("t4_drop_count", 32'(drop_count), 32'd3);
        chk("t4_pkt_count", 32'(pkt_count), 32'd3);
        @(negedge clk);
        chk("t4_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // 5: 1-byte packet, setup raised during lookup is held off
        push(2'd3, 8'h33, 1'b1, 1'b1); send_byte(8'h33, 1'b1, 1'b1);
        setup    = 1'b1;
        cfg_addr = 8'h44;
        cfg_port = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_rt_setup_busy", 32'(rt_setup), 32'd0);
            chk("t5_lkp_addr_held", 32'(lkp_addr), 32'h33);
            chk("t5_in_ready_busy", 32'(bus.in_ready), 32'd0);
        end
        drain();
        chk("t5_pkt_count", 32'(pkt_count), 32'd4);
        @(negedge clk);
        chk("t5_rt_setup_idle", 32'(rt_setup), 32'd1);
        chk("t5_in_ready_setup", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        setup = 1'b0;

        // 6: reset in BODY abandons the packet
        push(2'd1, 8'h22, 1'b1, 1'b0); send_byte(8'h22, 1'b1, 1'b0);
        push(2'd1, 8'hC0, 1'b0, 1'b0); send_byte(8'hC0, 1'b0, 1'b0);
        chk("t6_queue_before_reset", 32'(q.size()), 32'd0);
        bus.in_data  = 8'hC1;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_valid = 1'b1;
        reset        = 1'b1;
        @(negedge clk);
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_pkt_count", 32'(pkt_count), 32'd0);
        chk("t6_drop_count", 32'(drop_count), 32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_lkp_addr", 32'(lkp_addr), 32'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        push(2'd2, 8'h11, 1'b1, 1'b1); send_byte(8'h11, 1'b1, 1'b1);
        drain();
        chk("t6_post_pkt_count", 32'(pkt_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
